// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN: trivial cases (div by zero, signed overflow, zero multiply) skip the iteration.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [2:0]          f3_q;
   logic [XLEN-1:0]     opnd;
   logic [XLEN-1:0]     a_raw;
   logic [2*XLEN-1:0]   prod;
   logic                neg_q, neg_r, b_zero, ovf, mul_zero;

   logic                a_sgn, b_sgn, a_neg, b_neg;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                in_ovf;
   logic [XLEN:0]       mul_sum, r_sh, diff;
   logic [2*XLEN-1:0]   prod_step, mul_p;
   logic [XLEN-1:0]     quo, rem, fin_res;
`ifdef MULDIV_EARLY_OUT_EN
   logic                early;
`endif

   always_comb begin
      a_sgn  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
      b_sgn  = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      a_neg  = a_sgn & op_a[XLEN-1];
      b_neg  = b_sgn & op_b[XLEN-1];
      a_mag  = a_neg ? -op_a : op_a;
      b_mag  = b_neg ? -op_b : op_b;
      in_ovf = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
      early  = funct3[2] ? ((op_b == '0) | in_ovf) : ((op_a == '0) | (op_b == '0));
`endif

      // prod holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
      mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
      r_sh    = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
      diff    = r_sh - {1'b0, opnd};
      if (!f3_q[2])
         prod_step = {mul_sum, prod[XLEN-1:1]};
      else if (!diff[XLEN])
         prod_step = {diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
      else
         prod_step = {r_sh[XLEN-1:0], prod[XLEN-2:0], 1'b0};

      mul_p = neg_q ? -prod : prod;
      quo   = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
      rem   = neg_r ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
      if (b_zero) begin
         quo = '1;
         rem = a_raw;
      end else if (ovf) begin
         quo = {1'b1, {(XLEN-1){1'b0}}};
         rem = '0;
      end
      case (f3_q)
         3'b000:                 fin_res = mul_p[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_res = mul_p[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_res = quo;
         default:                fin_res = rem;
      endcase
      if (mul_zero && !f3_q[2])
         fin_res = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         f3_q     <= '0;
         opnd     <= '0;
         a_raw    <= '0;
         prod     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         b_zero   <= 1'b0;
         ovf      <= 1'b0;
         mul_zero <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (valid) begin
                  f3_q     <= funct3;
                  a_raw    <= op_a;
                  opnd     <= funct3[2] ? b_mag : a_mag;
                  prod     <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  b_zero   <= (op_b == '0);
                  ovf      <= in_ovf;
                  mul_zero <= (op_a == '0) | (op_b == '0);
`ifdef MULDIV_EARLY_OUT_EN
                  cnt      <= early ? '0 : CW'(XLEN-1);
`else
                  cnt      <= CW'(XLEN-1);
`endif
                  busy     <= 1'b1;
                  state    <= CALC;
               end
               CALC: begin
                  prod <= prod_step;
                  cnt  <= cnt - 1'b1;
                  if (cnt == '0)
                     state <= FIN;
               end
               FIN: begin
                  result <= fin_res;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: results, latency, busy/done timing, flush and reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, done;
   logic [31:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (valid),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // intf: drive a different request while busy; it must be ignored
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit sp, input bit intf);
      int lat = 0;
      int busy_lo = 0;
      int exp_lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
      if (sp) exp_lat = 2;
`else
      if (sp) exp_lat = 33;
`endif
      @(negedge clk);
      valid = 1'b1; funct3 = f; op_a = a; op_b = b;
      @(posedge clk); #1;
      valid = 1'b0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) busy_lo++;
         if (intf) begin
            valid  = (lat >= 3 && lat < 8);
            funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
         end
         @(posedge clk); #1;
         lat++;
      end
      valid = 1'b0;
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, result, exp);
      check({tag, "_busy_run"}, 32'(busy_lo), 32'd0);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic no_done(input string tag, input int cycles);
      int seen = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      run_op("mul",      3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0);
      run_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0);
      run_op("mulh_m1",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
      run_op("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
      run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op("div_n7",   3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_op("rem_n7",   3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_op("div_7n2",  3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
      run_op("rem_7n2",  3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
      run_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0);
      run_op("remu",     3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0);
      run_op("div_z",    3'b100, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_op("rem_z",    3'b110, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 1'b0);
      run_op("div_nz",   3'b100, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0);
      run_op("remu_z",   3'b111, 32'h00000005, 32'h00000000, 32'h00000005, 1'b1, 1'b0);
      run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
      run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
      run_op("mul_za",   3'b000, 32'h00000000, 32'h00000006, 32'h00000000, 1'b1, 1'b0);
      run_op("mulhu_zb", 3'b011, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 1'b0);

      // flush in CALC: no done, result untouched
      @(negedge clk);
      valid = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      no_done("flush_nodone", 40);
      check("flush_result", result, 32'h00000000);

      // flush and valid together in IDLE: request dropped
      @(negedge clk); valid = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd5;
      @(posedge clk); #1; valid = 1'b0; flush = 1'b0;
      check("flush_idle_busy", 32'(busy), 32'd0);
      no_done("flush_idle_nodone", 40);

      run_op("mul_3x4",  3'b000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
      run_op("divu_intf", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);

      // asynchronous reset mid-CALC
      @(negedge clk);
      valid = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      no_done("arst_nodone", 40);

      run_op("mul_post", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
